// File: rtl/stage_sequencer.sv
// stage_sequencer: chain of NUM_STAGES identical stage FSMs (IDLE/ACTIVE/DONE/ERROR)
// with DONE-to-ACTIVE hand-off backpressure, per-stage ACTIVE timeout and a
// sticky error report naming the first stage that timed out.
module stage_sequencer #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TO_W       = 8,
  parameter int unsigned IDX_W      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_ready,
  output logic                  start_ready,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_enable,
  input  logic                  abort,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  err,
  output logic [IDX_W-1:0]      err_stage
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  // Counter value seen in the last permitted ACTIVE cycle
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e                state_q [NUM_STAGES];
  state_e                state_d [NUM_STAGES];
  logic [TO_W-1:0]       cnt_q   [NUM_STAGES];
  logic [TO_W-1:0]       cnt_d   [NUM_STAGES];

  logic [NUM_STAGES-1:0] prev_done;
  logic [NUM_STAGES-1:0] next_idle;
  logic [NUM_STAGES-1:0] to_hit;

  logic [NUM_STAGES-1:0] enable_d;
  logic                  busy_d;
  logic                  seq_done_d;
  logic                  start_ready_d;
  logic                  err_d;
  logic [IDX_W-1:0]      err_stage_d;
  logic [IDX_W-1:0]      first_idx;

  // Hand-off qualifiers: what each stage's neighbours look like this cycle
  always_comb begin
    prev_done                 = '0;
    next_idle                 = '0;
    prev_done[0]              = data_ready;
    next_idle[NUM_STAGES-1]   = 1'b1;
    for (int k = 1; k < NUM_STAGES; k++) begin
      prev_done[k]   = (state_q[k-1] == ST_DONE);
      next_idle[k-1] = (state_q[k] == ST_IDLE);
    end
  end

  // Per-stage next state and timeout counter
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = '0;
      to_hit[k]  = 1'b0;
      case (state_q[k])
        ST_IDLE: begin
          if (!abort && prev_done[k]) begin
            state_d[k] = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (abort) begin
            state_d[k] = ST_IDLE;
          end else if (stage_done[k]) begin
            state_d[k] = ST_DONE;
          end else if (TO_EN && (cnt_q[k] == TO_LAST)) begin
            state_d[k] = ST_ERROR;
            to_hit[k]  = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + TO_W'(1);
          end
        end
        ST_DONE: begin
          // A DONE stage leaves only on the edge its successor takes the item
          if (abort || next_idle[k]) begin
            state_d[k] = ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (err_clr) begin
            state_d[k] = ST_IDLE;
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
        end
      endcase
    end
  end

  // Lowest-index stage timing out this cycle
  always_comb begin
    first_idx = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (to_hit[k]) begin
        first_idx = IDX_W'(k);
      end
    end
  end

  // Next values of the registered outputs and the sticky error report
  always_comb begin
    enable_d = '0;
    busy_d   = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      enable_d[k] = (state_d[k] == ST_ACTIVE);
      if (state_d[k] != ST_IDLE) begin
        busy_d = 1'b1;
      end
    end
    seq_done_d    = (state_d[NUM_STAGES-1] == ST_DONE);
    start_ready_d = (state_d[0] == ST_IDLE);

    err_d       = err;
    err_stage_d = err_stage;
    if ((|to_hit) && (!err || err_clr)) begin
      err_d       = 1'b1;
      err_stage_d = first_idx;
    end else if (err_clr) begin
      err_d       = 1'b0;
      err_stage_d = '0;
    end
  end

  // State, counters and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
      stage_enable <= '0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      start_ready  <= 1'b1;
      err          <= 1'b0;
      err_stage    <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      stage_enable <= enable_d;
      busy         <= busy_d;
      seq_done     <= seq_done_d;
      start_ready  <= start_ready_d;
      err          <= err_d;
      err_stage    <= err_stage_d;
    end
  end

endmodule
